retire_trace_fifo: RTL

Buffers the hart's per-instruction retire stream into a small FIFO and replays it to a trace consumer over a valid/ready handshake, with cycle and retired-instruction counters and halt-driven drain/done sequencing. It sits directly downstream of the hart's `o_retire_*` port. Simulation benches and the on-chip trace port drain it at their own pace, so they need not sample the retire interface on the exact retire cycle.

---
 rtl/retire_trace_fifo.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/retire_trace_fifo.sv
// retire_trace_fifo: buffers the hart retire stream in a small FWFT FIFO and
// replays it over valid/ready, with cycle/instret/drop counters and a
// RUN -> DRAIN -> DONE sequence driven by a retired halt.
module retire_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_retire_valid,
    input  logic [31:0]              i_retire_inst,
    input  logic [31:0]              i_retire_pc,
    input  logic [31:0]              i_retire_next_pc,
    input  logic [4:0]               i_retire_rd_waddr,
    input  logic [31:0]              i_retire_rd_wdata,
    input  logic                     i_retire_trap,
    input  logic                     i_retire_halt,
    output logic                     o_trace_valid,
    input  logic                     i_trace_ready,
    output logic [31:0]              o_trace_inst,
    output logic [31:0]              o_trace_pc,
    output logic [31:0]              o_trace_next_pc,
    output logic [4:0]               o_trace_rd_waddr,
    output logic [31:0]              o_trace_rd_wdata,
    output logic                     o_trace_trap,
    output logic                     o_trace_halt,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic [CNT_W-1:0]         o_dropped,
    output logic                     o_halted,
    output logic                     o_done,
    output logic [CNT_W-1:0]         o_cycles,
    output logic [CNT_W-1:0]         o_instret
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [4:0]  rd_waddr;
        logic [31:0] rd_wdata;
        logic        trap;
        logic        halt;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           wr_entry;
    entry_t           head;

    state_t           state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] dropped_q, dropped_d;
    logic             halted_q, halted_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic             full;
    logic             pop;
    logic             capture;
    logic             push;
    logic             drop;

    // Entry as stored: x0 writes never carry data, so the trace shows 0.
    always_comb begin
        wr_entry          = '0;
        wr_entry.inst     = i_retire_inst;
        wr_entry.pc       = i_retire_pc;
        wr_entry.next_pc  = i_retire_next_pc;
        wr_entry.rd_waddr = i_retire_rd_waddr;
        wr_entry.rd_wdata = (i_retire_rd_waddr == 5'd0) ? 32'd0 : i_retire_rd_wdata;
        wr_entry.trap     = i_retire_trap;
        wr_entry.halt     = i_retire_halt;
    end

    // Next-state logic: handshake, pointers, counters and RUN/DRAIN/DONE sequencing.
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        halted_d   = halted_q;
        done_d     = done_q;
        cycles_d   = cycles_q;
        instret_d  = instret_q;

        full    = (count_q == CW'(DEPTH));
        pop     = (count_q != '0) && i_trace_ready;
        capture = (state_q == S_RUN) && i_retire_valid;
        // A full FIFO still takes the entry when the head leaves in the same cycle.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;

        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        count_d = count_q + CW'(push) - CW'(pop);

        if (drop) begin
            overflow_d = 1'b1;
            dropped_d  = dropped_q + CNT_W'(1);
        end

        case (state_q)
            S_RUN: begin
                cycles_d = cycles_q + CNT_W'(1);
                if (capture) begin
                    instret_d = instret_q + CNT_W'(1);
                    if (i_retire_halt) begin
                        state_d  = S_DRAIN;
                        halted_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_DONE;
        endcase
    end

    // Control and counter registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= S_RUN;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            halted_q   <= 1'b0;
            done_q     <= 1'b0;
            cycles_q   <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            halted_q   <= halted_d;
            done_q     <= done_d;
            cycles_q   <= cycles_d;
            instret_q  <= instret_d;
        end
    end

    // Storage array; contents need no reset since pointers/count gate visibility.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && push) mem_q[wptr_q] <= wr_entry;
    end

    // First-word-fall-through head; fields only meaningful while valid.
    always_comb begin
        head = mem_q[rptr_q];
    end

    assign o_trace_valid    = (count_q != '0);
    assign o_trace_inst     = head.inst;
    assign o_trace_pc       = head.pc;
    assign o_trace_next_pc  = head.next_pc;
    assign o_trace_rd_waddr = head.rd_waddr;
    assign o_trace_rd_wdata = head.rd_wdata;
    assign o_trace_trap     = head.trap;
    assign o_trace_halt     = head.halt;
    assign o_count          = count_q;
    assign o_overflow       = overflow_q;
    assign o_dropped        = dropped_q;
    assign o_halted         = halted_q;
    assign o_done           = done_q;
    assign o_cycles         = cycles_q;
    assign o_instret        = instret_q;

endmodule
